// File: rtl/rv16_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv16_pkg
// Purpose : Shared types and sizing constants for the rv16 FU dispatch slice.
//           fu_op_e names the opcode values; opcode value i targets FU i.
// Ports   : (package - none)
// Rev     : 1.0  initial release
// ============================================================================
package rv16_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_XOR = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6
  } fu_op_e;

  localparam int RV16_NUM_FU = 7;
  localparam int RV16_DATA   = 16;

endpackage : rv16_pkg
`default_nettype wire

// File: rtl/rv16_fu_slot.sv
`default_nettype none
// ============================================================================
// Module  : rv16_fu_slot
// Purpose : One-entry valid/ready holding register in front of a single FU.
//           Outputs are gated to zero while the slot is empty.
// Ports   : clk, rst_n      clock, async active-low reset
//           load_i          write rs1_d_i/rs2_d_i into the slot this cycle
//           rs1_d_i/rs2_d_i operands to load
//           ready_i         FU consumes the slot contents this cycle
//           valid_o         slot holds an op
//           rs1_q_o/rs2_q_o held operands (0 when empty)
//           can_load_o      slot is empty or draining this cycle
// Rev     : 1.0  initial release
// ============================================================================
module rv16_fu_slot
  import rv16_pkg::*;
#(
  parameter int DATA = RV16_DATA
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [DATA-1:0] rs1_d_i,
  input  logic [DATA-1:0] rs2_d_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [DATA-1:0] rs1_q_o,
  output logic [DATA-1:0] rs2_q_o,
  output logic            can_load_o
);

  logic            valid_q, valid_d;
  logic [DATA-1:0] rs1_q, rs1_d;
  logic [DATA-1:0] rs2_q, rs2_d;

  // A draining slot can accept a new op in the same cycle: full throughput.
  assign can_load_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    if (load_i) begin
      valid_d = 1'b1;
      rs1_d   = rs1_d_i;
      rs2_d   = rs2_d_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign valid_o = valid_q;
  // Gate the data so an empty slot never exposes a stale operand.
  assign rs1_q_o = valid_q ? rs1_q : '0;
  assign rs2_q_o = valid_q ? rs2_q : '0;

endmodule : rv16_fu_slot
`default_nettype wire

// File: rtl/rv16_fu_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : rv16_fu_dispatch
// Purpose : Routes one (rs1, rs2) operand pair per cycle into the holding slot
//           of the FU selected by the opcode. Ops with an opcode >= NUM_FU are
//           dropped and counted by a saturating counter.
// Ports   : clk, rst_n              clock, async active-low reset
//           in_valid_i/in_ready_o   upstream handshake
//           in_opcode_i             target FU index
//           in_rs1_i/in_rs2_i       operands
//           fu_valid_o/fu_ready_i   per-FU slot handshake
//           fu_rs1_o/fu_rs2_o       slot i operands at [i*DATA +: DATA]
//           illegal_op_o            one-cycle pulse after an illegal op is dropped
//           illegal_cnt_o           saturating count of dropped illegal ops
// Rev     : 1.0  initial release
// ============================================================================
module rv16_fu_dispatch
  import rv16_pkg::*;
#(
  parameter int DATA   = RV16_DATA,
  parameter int OPW    = 4,
  parameter int NUM_FU = RV16_NUM_FU,
  parameter int CNTW   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [OPW-1:0]         in_opcode_i,
  input  logic [DATA-1:0]        in_rs1_i,
  input  logic [DATA-1:0]        in_rs2_i,
  output logic [NUM_FU-1:0]      fu_valid_o,
  input  logic [NUM_FU-1:0]      fu_ready_i,
  output logic [NUM_FU*DATA-1:0] fu_rs1_o,
  output logic [NUM_FU*DATA-1:0] fu_rs2_o,
  output logic                   illegal_op_o,
  output logic [CNTW-1:0]        illegal_cnt_o
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [NUM_FU-1:0] sel;       // one-hot opcode decode, all zero if illegal
  logic [NUM_FU-1:0] can_load;
  logic [NUM_FU-1:0] load;
  logic              legal;
  logic              illegal_d, illegal_q;
  logic [CNTW-1:0]   cnt_d, cnt_q;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
    assign sel[i]  = (in_opcode_i == OPW'(i));
    assign load[i] = in_valid_i && sel[i] && can_load[i];

    rv16_fu_slot #(
      .DATA (DATA)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load[i]),
      .rs1_d_i    (in_rs1_i),
      .rs2_d_i    (in_rs2_i),
      .ready_i    (fu_ready_i[i]),
      .valid_o    (fu_valid_o[i]),
      .rs1_q_o    (fu_rs1_o[i*DATA +: DATA]),
      .rs2_q_o    (fu_rs2_o[i*DATA +: DATA]),
      .can_load_o (can_load[i])
    );
  end

  assign legal = |sel;

  // Illegal ops are always accepted (and dropped); legal ops wait on their slot.
  // in_valid_i deliberately does not feed in_ready_o.
  assign in_ready_o = legal ? |(sel & can_load) : 1'b1;

  always_comb begin
    illegal_d = in_valid_i && !legal;
    cnt_d     = cnt_q;
    if (illegal_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign illegal_op_o  = illegal_q;
  assign illegal_cnt_o = cnt_q;

endmodule : rv16_fu_dispatch
`default_nettype wire

// File: tb/tb_rv16_fu_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv16_fu_dispatch
// Purpose : Self-checking bench for rv16_fu_dispatch: directed table, corner
//           sequences and randomized traffic against a per-FU queue model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_rv16_fu_dispatch;

  localparam int DATA = 16;
  localparam int OPW  = 4;
  localparam int NFU  = 7;
  localparam int CNTW = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [OPW-1:0]       in_opcode;
  logic [DATA-1:0]      in_rs1, in_rs2;
  logic [NFU-1:0]       fu_valid, fu_ready;
  logic [NFU*DATA-1:0]  fu_rs1, fu_rs2;
  logic                 illegal_op;
  logic [CNTW-1:0]      illegal_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv16_fu_dispatch #(
    .DATA(DATA), .OPW(OPW), .NUM_FU(NFU), .CNTW(CNTW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_opcode_i   (in_opcode),
    .in_rs1_i      (in_rs1),
    .in_rs2_i      (in_rs2),
    .fu_valid_o    (fu_valid),
    .fu_ready_i    (fu_ready),
    .fu_rs1_o      (fu_rs1),
    .fu_rs2_o      (fu_rs2),
    .illegal_op_o  (illegal_op),
    .illegal_cnt_o (illegal_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic [NFU-1:0] rdy);
    in_opcode = op;
    in_valid  = v;
    in_rs1    = a;
    in_rs2    = b;
    fu_ready  = rdy;
  endtask

  task automatic to_sync();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]     op;
    logic           v;
    logic [15:0]    a, b;
    logic [NFU-1:0] rdy;
    logic           e_ready;
    logic [NFU-1:0] e_fv;
    logic           e_ill;
    int             slot;
    logic [15:0]    e_a, e_b;
  } vec_t;

  vec_t tbl[10];

  // Random-phase model: each FU's slot is a queue of accepted, undelivered ops.
  logic [31:0] q[NFU][$];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n_xfer;
    int exp_cnt;
    logic [NFU*DATA-1:0] e1, e2;
    logic [NFU-1:0] efv;
    logic exp_rdy, exp_ill;
    logic [3:0] op;
    logic v;
    logic [15:0] a, b;
    logic [NFU-1:0] rdy;

    //          op     v  rs1      rs2      rdy        rdy fv         ill slot e_rs1    e_rs2
    tbl[0] = '{4'd2,  1, 16'h1234, 16'h0005, 7'b0000000, 1, 7'b0000100, 0, 2, 16'h1234, 16'h0005};
    tbl[1] = '{4'd2,  1, 16'hAAAA, 16'hBBBB, 7'b0000000, 0, 7'b0000100, 0, 2, 16'h1234, 16'h0005};
    tbl[2] = '{4'd4,  1, 16'h4444, 16'h0004, 7'b0000000, 1, 7'b0010100, 0, 4, 16'h4444, 16'h0004};
    tbl[3] = '{4'd7,  1, 16'h7777, 16'h7777, 7'b0000000, 1, 7'b0010100, 1, 0, 16'h0000, 16'h0000};
    tbl[4] = '{4'd15, 1, 16'hFFFF, 16'hFFFF, 7'b0000000, 1, 7'b0010100, 1, 2, 16'h1234, 16'h0005};
    tbl[5] = '{4'd1,  0, 16'h1111, 16'h1111, 7'b0000100, 1, 7'b0010000, 0, 2, 16'h0000, 16'h0000};
    tbl[6] = '{4'd1,  1, 16'hBEEF, 16'h0001, 7'b0000000, 1, 7'b0010010, 0, 1, 16'hBEEF, 16'h0001};
    tbl[7] = '{4'd1,  1, 16'hCAFE, 16'h0002, 7'b0000010, 1, 7'b0010010, 0, 1, 16'hCAFE, 16'h0002};
    tbl[8] = '{4'd4,  0, 16'h9999, 16'h9999, 7'b1111111, 1, 7'b0000000, 0, 4, 16'h0000, 16'h0000};
    tbl[9] = '{4'd7,  0, 16'h8888, 16'h8888, 7'b0000000, 1, 7'b0000000, 0, 1, 16'h0000, 16'h0000};

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    drive(4'd0, 1'b0, 16'h0, 16'h0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fu_valid", 128'(fu_valid), 128'd0);
    chk("rst_fu_rs1", 128'(fu_rs1), 128'd0);
    chk("rst_fu_rs2", 128'(fu_rs2), 128'd0);
    chk("rst_illegal_op", 128'(illegal_op), 128'd0);
    chk("rst_illegal_cnt", 128'(illegal_cnt), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    to_sync();

    // ---------------- directed table ----------------
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].op, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), 128'(in_ready), 128'(tbl[i].e_ready));
      to_sync();
      chk($sformatf("tbl%0d_fu_valid", i), 128'(fu_valid), 128'(tbl[i].e_fv));
      chk($sformatf("tbl%0d_illegal_op", i), 128'(illegal_op), 128'(tbl[i].e_ill));
      chk($sformatf("tbl%0d_rs1", i), 128'(fu_rs1[tbl[i].slot*DATA +: DATA]), 128'(tbl[i].e_a));
      chk($sformatf("tbl%0d_rs2", i), 128'(fu_rs2[tbl[i].slot*DATA +: DATA]), 128'(tbl[i].e_b));
    end
    chk("tbl_illegal_cnt", 128'(illegal_cnt), 128'd2);

    // ---------------- backpressure: slot 2 held 10 cycles ----------------
    drive(4'd2, 1'b1, 16'h1234, 16'h0005, '0);
    to_sync();
    drive(4'd2, 1'b1, 16'hAAAA, 16'hBBBB, '0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      to_sync();
      chk("bp_fu_valid", 128'(fu_valid), 128'b0000100);
      chk("bp_rs1", 128'(fu_rs1), 128'(16'h1234) << (2*DATA));
      chk("bp_rs2", 128'(fu_rs2), 128'(16'h0005) << (2*DATA));
    end
    drive(4'd4, 1'b1, 16'h4444, 16'h0004, '0);
    @(negedge clk);
    chk("bp_other_ready", 128'(in_ready), 128'd1);
    to_sync();
    chk("bp_other_fu_valid", 128'(fu_valid), 128'b0010100);
    drive(4'd0, 1'b0, 16'h0, 16'h0, '1);
    to_sync();
    chk("bp_drained", 128'(fu_valid), 128'd0);

    // ---------------- streaming 8 ops into FU 1 ----------------
    n_xfer = 0;
    for (int k = 0; k < 8; k++) begin
      drive(4'd1, 1'b1, 16'hB000 + 16'(k), 16'h00A0 + 16'(k), 7'b0000010);
      @(negedge clk);
      if (in_ready) n_xfer++;
      to_sync();
      chk("stream_fu_valid", 128'(fu_valid), 128'b0000010);
      chk("stream_rs1", 128'(fu_rs1[1*DATA +: DATA]), 128'(16'hB000 + 16'(k)));
    end
    chk("stream_transfers", 128'(n_xfer), 128'd8);
    drive(4'd0, 1'b0, 16'h0, 16'h0, '1);
    to_sync();

    // ---------------- illegal-counter saturation ----------------
    for (int k = 0; k < 300; k++) begin
      drive(4'(7 + $urandom_range(0, 8)), 1'b1, 16'(k), 16'(k), '0);
      to_sync();
    end
    chk("sat_illegal_cnt", 128'(illegal_cnt), 128'd255);
    chk("sat_fu_valid", 128'(fu_valid), 128'd0);

    // ---------------- async reset with slots 0 and 3 full ----------------
    drive(4'd0, 1'b1, 16'h0A0A, 16'h0B0B, '0);
    to_sync();
    drive(4'd3, 1'b1, 16'h3A3A, 16'h3B3B, '0);
    to_sync();
    chk("pre_rst_fu_valid", 128'(fu_valid), 128'b0001001);
    drive(4'd0, 1'b0, 16'h0, 16'h0, '0);
    #2;
    rst_n = 1'b0;
    #1;  // still before the next rising edge
    chk("arst_fu_valid", 128'(fu_valid), 128'd0);
    chk("arst_rs1", 128'(fu_rs1), 128'd0);
    chk("arst_rs2", 128'(fu_rs2), 128'd0);
    chk("arst_illegal_cnt", 128'(illegal_cnt), 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    to_sync();
    chk("post_rst_no_replay", 128'(fu_valid), 128'd0);

    // ---------------- randomized traffic vs queue model ----------------
    exp_cnt = 0;
    for (int k = 0; k < 2000; k++) begin
      op  = 4'($urandom_range(0, 15));
      v   = ($urandom_range(0, 3) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      rdy = NFU'($urandom);
      drive(op, v, a, b, rdy);
      @(negedge clk);
      exp_rdy = (op >= 4'(NFU)) || (q[op].size() == 0) || rdy[op];
      chk("rnd_in_ready", 128'(in_ready), 128'(exp_rdy));
      // model update for this edge: drains, then the single possible load
      for (int i = 0; i < NFU; i++)
        if (q[i].size() != 0 && rdy[i]) void'(q[i].pop_front());
      if (v && exp_rdy && op < 4'(NFU)) q[op].push_back({a, b});
      exp_ill = v && (op >= 4'(NFU));
      if (exp_ill && exp_cnt < 255) exp_cnt++;
      to_sync();
      efv = '0;
      e1  = '0;
      e2  = '0;
      for (int i = 0; i < NFU; i++) begin
        if (q[i].size() != 0) begin
          efv[i] = 1'b1;
          e1[i*DATA +: DATA] = q[i][0][31:16];
          e2[i*DATA +: DATA] = q[i][0][15:0];
        end
      end
      chk("rnd_fu_valid", 128'(fu_valid), 128'(efv));
      chk("rnd_fu_rs1", 128'(fu_rs1), 128'(e1));
      chk("rnd_fu_rs2", 128'(fu_rs2), 128'(e2));
      chk("rnd_illegal_op", 128'(illegal_op), 128'(exp_ill));
      chk("rnd_illegal_cnt", 128'(illegal_cnt), 128'(exp_cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rv16_fu_dispatch
`default_nettype wire
